// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bundles the receive-side handshake (byte + ready), the CPU drain port
// (pop / dout / status) and the overrun flag of the UART receive FIFO.
//   master : the environment (UART receiver + GPIO/MMIO read path)
//   slave  : the FIFO itself
// Signals:
//   rx_byte       byte from the UART receiver
//   rx_byte_ready receiver ready; every 0->1 transition pushes rx_byte
//   pop           remove the head entry
//   dout          head entry (first-word-fall-through), valid while empty=0
//   empty / full  occupancy flags
//   count         number of entries, 0..DEPTH
//   overrun       sticky "byte dropped because full" flag
//   overrun_clr   clears overrun (a simultaneous set wins)
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_byte;
    logic          rx_byte_ready;
    logic          pop;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          overrun_clr;

    modport master (
        output rx_byte,
        output rx_byte_ready,
        output pop,
        output overrun_clr,
        input  dout,
        input  empty,
        input  full,
        input  count,
        input  overrun
    );

    modport slave (
        input  rx_byte,
        input  rx_byte_ready,
        input  pop,
        input  overrun_clr,
        output dout,
        output empty,
        output full,
        output count,
        output overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive buffer between the UART receiver and the GPIO/MMIO load path.
// Each rising edge of rx_byte_ready pushes rx_byte into a first-word-fall-
// through FIFO; the CPU drains it with pop. A byte arriving while the FIFO
// is full (and not being popped in the same cycle) is dropped and recorded
// in the sticky overrun flag.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  uart_rx_fifo_if.slave (rx_byte, rx_byte_ready, pop, dout, empty,
//        full, count, overrun, overrun_clr)
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rdy_q;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] wp_d;
    logic [AW-1:0] rp_q;
    logic [AW-1:0] rp_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overrun_q;
    logic          overrun_d;
    logic [7:0]    mem_q [DEPTH];

    logic          empty_s;
    logic          full_s;
    logic          push_req_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic          drop_s;

    // Edge detect, push/pop qualification and next-state computation
    always_comb begin
        empty_s    = (count_q == CW'(0));
        full_s     = (count_q == CW'(DEPTH));
        push_req_s = bus.rx_byte_ready & ~rdy_q;
        do_pop_s   = bus.pop & ~empty_s;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push_s  = push_req_s & (~full_s | do_pop_s);
        drop_s     = push_req_s & full_s & ~do_pop_s;

        if (do_push_s) begin
            wp_d = wp_q + AW'(1);
        end else begin
            wp_d = wp_q;
        end

        if (do_pop_s) begin
            rp_d = rp_q + AW'(1);
        end else begin
            rp_d = rp_q;
        end

        count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);

        // Set has priority over clear so a drop is never lost
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Control state: pointers, count, overrun and ready history
    always_ff @(posedge clk) begin
        if (rst) begin
            // Load the current level so a ready held high across reset
            // release is not seen as a new byte
            rdy_q     <= bus.rx_byte_ready;
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rdy_q     <= bus.rx_byte_ready;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Byte storage; contents are intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (do_push_s && !rst) begin
            mem_q[wp_q] <= bus.rx_byte;
        end
    end

    assign bus.dout    = mem_q[rp_q];
    assign bus.empty   = empty_s;
    assign bus.full    = full_s;
    assign bus.count   = count_q;
    assign bus.overrun = overrun_q;

endmodule
